score_display: RTL



---
 rtl/score_display_pkg.sv | 31 +++
 rtl/score_display_bcd_to_7seg.sv | 27 ++
 rtl/score_display.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display: FSM encoding, active-high
// abcdefg segment patterns (bit6 = A ... bit0 = G) and the double-dabble step helper.
package score_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_LATCH   = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;

    localparam logic [7:0] SCORE_MAX   = 8'd99;
    localparam logic [2:0] LAST_STEP   = 3'd7;

    // Double-dabble correction applied to one BCD nibble before each shift.
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/score_display_bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder, active-high abcdefg output.
// Codes 10..15 are not digits and decode to a blank display.
module score_display_bcd_to_7seg
    import score_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Converts the game's binary score to two 7-segment digits via a sequential
// double-dabble, and blinks the display for a short burst when the score goes up.
module score_display
    import score_display_pkg::*;
#(
    parameter int c_SEG_ACTIVE_LOW     = 1,
    parameter int c_BLANK_LEADING_ZERO = 1,
    parameter int c_BLINK_HALF         = 6250000,
    parameter int c_BLINK_TOGGLES      = 6
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_Score,
    output logic [6:0] o_Segment_Tens,
    output logic [6:0] o_Segment_Ones,
    output logic       o_Busy,
    output logic       o_Overflow
);

    localparam int HALF_W = (c_BLINK_HALF > 1) ? $clog2(c_BLINK_HALF) : 1;
    localparam int TOG_W  = (c_BLINK_TOGGLES > 1) ? $clog2(c_BLINK_TOGGLES) : 1;
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(c_BLINK_HALF - 1);
    localparam logic [TOG_W-1:0]  TOG_LAST  = TOG_W'(c_BLINK_TOGGLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  shown_bin_q, shown_bin_d;
    logic [7:0]  raw_q, raw_d;
    logic [7:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [2:0]  iter_q, iter_d;
    logic        ovf_pend_q, ovf_pend_d;
    logic [3:0]  tens_nib_q, tens_nib_d;
    logic [3:0]  ones_nib_q, ones_nib_d;
    logic        overflow_q, overflow_d;
    logic        latched_once_q, latched_once_d;
    logic        blink_start;

    logic              blink_active_q, blink_active_d;
    logic              blink_off_q, blink_off_d;
    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic [TOG_W-1:0]  toggle_cnt_q, toggle_cnt_d;

    logic [3:0] adj_h, adj_t, adj_o;

    // Conversion FSM
    always_comb begin
        state_d        = state_q;
        shown_bin_d    = shown_bin_q;
        raw_d          = raw_q;
        bin_d          = bin_q;
        bcd_d          = bcd_q;
        iter_d         = iter_q;
        ovf_pend_d     = ovf_pend_q;
        tens_nib_d     = tens_nib_q;
        ones_nib_d     = ones_nib_q;
        overflow_d     = overflow_q;
        latched_once_d = latched_once_q;
        blink_start    = 1'b0;

        adj_h = dabble_adj(bcd_q[11:8]);
        adj_t = dabble_adj(bcd_q[7:4]);
        adj_o = dabble_adj(bcd_q[3:0]);

        case (state_q)
            ST_IDLE: begin
                if (i_Score != shown_bin_q) begin
                    raw_d = i_Score;
                    if (i_Score > SCORE_MAX) begin
                        bin_d      = SCORE_MAX;
                        ovf_pend_d = 1'b1;
                    end else begin
                        bin_d      = i_Score;
                        ovf_pend_d = 1'b0;
                    end
                    bcd_d   = 12'd0;
                    iter_d  = 3'd0;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                bcd_d  = {adj_h[2:0], adj_t, adj_o, bin_q[7]};
                bin_d  = {bin_q[6:0], 1'b0};
                // A carry out of the hundreds nibble cannot happen with a clamped
                // input, but if it ever did the digits would be wrong: flag it.
                ovf_pend_d = ovf_pend_q | adj_h[3];
                iter_d = iter_q + 3'd1;
                if (iter_q == LAST_STEP) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                tens_nib_d     = bcd_q[7:4];
                ones_nib_d     = bcd_q[3:0];
                overflow_d     = ovf_pend_q | (bcd_q[11:8] != 4'd0);
                shown_bin_d    = raw_q;
                latched_once_d = 1'b1;
                blink_start    = latched_once_q && (raw_q > shown_bin_q);
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Blink burst: starts in the OFF phase, ends forced ON after the last half-period.
    always_comb begin
        blink_active_d = blink_active_q;
        blink_off_d    = blink_off_q;
        half_cnt_d     = half_cnt_q;
        toggle_cnt_d   = toggle_cnt_q;

        if (blink_start) begin
            blink_active_d = 1'b1;
            blink_off_d    = 1'b1;
            half_cnt_d     = '0;
            toggle_cnt_d   = '0;
        end else if (blink_active_q) begin
            if (half_cnt_q == HALF_LAST) begin
                half_cnt_d = '0;
                if (toggle_cnt_q == TOG_LAST) begin
                    blink_active_d = 1'b0;
                    blink_off_d    = 1'b0;
                    toggle_cnt_d   = '0;
                end else begin
                    blink_off_d  = ~blink_off_q;
                    toggle_cnt_d = toggle_cnt_q + TOG_W'(1);
                end
            end else begin
                half_cnt_d = half_cnt_q + HALF_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q        <= ST_IDLE;
            shown_bin_q    <= 8'd0;
            raw_q          <= 8'd0;
            bin_q          <= 8'd0;
            bcd_q          <= 12'd0;
            iter_q         <= 3'd0;
            ovf_pend_q     <= 1'b0;
            tens_nib_q     <= 4'd0;
            ones_nib_q     <= 4'd0;
            overflow_q     <= 1'b0;
            latched_once_q <= 1'b0;
            blink_active_q <= 1'b0;
            blink_off_q    <= 1'b0;
            half_cnt_q     <= '0;
            toggle_cnt_q   <= '0;
        end else begin
            state_q        <= state_d;
            shown_bin_q    <= shown_bin_d;
            raw_q          <= raw_d;
            bin_q          <= bin_d;
            bcd_q          <= bcd_d;
            iter_q         <= iter_d;
            ovf_pend_q     <= ovf_pend_d;
            tens_nib_q     <= tens_nib_d;
            ones_nib_q     <= ones_nib_d;
            overflow_q     <= overflow_d;
            latched_once_q <= latched_once_d;
            blink_active_q <= blink_active_d;
            blink_off_q    <= blink_off_d;
            half_cnt_q     <= half_cnt_d;
            toggle_cnt_q   <= toggle_cnt_d;
        end
    end

    logic [6:0] tens_raw, ones_raw;
    logic [6:0] tens_vis, ones_vis;

    score_display_bcd_to_7seg u_tens_dec (
        .bcd_i (tens_nib_q),
        .seg_o (tens_raw)
    );

    score_display_bcd_to_7seg u_ones_dec (
        .bcd_i (ones_nib_q),
        .seg_o (ones_raw)
    );

    // Latched digits stay intact underneath; blinking only masks the pins.
    always_comb begin
        tens_vis = tens_raw;
        ones_vis = ones_raw;
        if ((c_BLANK_LEADING_ZERO != 0) && (tens_nib_q == 4'd0)) begin
            tens_vis = SEG_BLANK;
        end
        if (blink_off_q) begin
            tens_vis = SEG_BLANK;
            ones_vis = SEG_BLANK;
        end
        if (c_SEG_ACTIVE_LOW != 0) begin
            o_Segment_Tens = ~tens_vis;
            o_Segment_Ones = ~ones_vis;
        end else begin
            o_Segment_Tens = tens_vis;
            o_Segment_Ones = ones_vis;
        end
    end

    assign o_Busy     = (state_q != ST_IDLE);
    assign o_Overflow = overflow_q;

endmodule
